// File: rtl/matrix_dma_pkg.sv
// Shared definitions for the matrix write/read DMA engines.
//   - dma_state_e      : FSM state encoding (IDLE, CMD, DAT, WAIT_RSP)
//   - field offsets    : bit positions of the command fields inside the MCIF word
//   - pb_bytes()       : bytes per beat derived from lane count and lane width
//   - pack_cmd()       : packs {base_addr, nonposted, len, offset} into the low bits
//                        of a fixed-width vector; the caller adds the command flag
//                        and zero pad above it.
package matrix_dma_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCmd     = 2'd1,
        StDat     = 2'd2,
        StWaitRsp = 2'd3
    } dma_state_e;

    // Command field layout, LSB upwards: offset, len, nonposted, base_addr.
    localparam int unsigned OffsetLsb = 0;
    localparam int unsigned LenLsb    = 32;
    localparam int unsigned CmdPackW  = 96;

    function automatic int unsigned np_lsb(input int unsigned log2_burst);
        return LenLsb + log2_burst;
    endfunction

    function automatic int unsigned base_lsb(input int unsigned log2_burst);
        return LenLsb + log2_burst + 1;
    endfunction

    // Width of the packed command fields (excludes flag bit and pad).
    function automatic int unsigned cmd_fields_w(input int unsigned log2_burst);
        return base_lsb(log2_burst) + 32;
    endfunction

    function automatic int unsigned pb_bytes(input int unsigned tout, input int unsigned dat_dw);
        return (tout * dat_dw) / 8;
    endfunction

    function automatic logic [CmdPackW-1:0] pack_cmd(
        input logic [31:0]    base_addr,
        input logic           nonposted,
        input logic [15:0]    len,
        input logic [31:0]    offset,
        input int unsigned    log2_burst
    );
        logic [CmdPackW-1:0] r;
        r = CmdPackW'(offset);
        r = r | (CmdPackW'(len) << LenLsb);
        r = r | (CmdPackW'(nonposted) << np_lsb(log2_burst));
        r = r | (CmdPackW'(base_addr) << base_lsb(log2_burst));
        return r;
    endfunction

endpackage

// File: rtl/matrix_wdma_if.sv
// Engine-stream and MCIF write-port bundle for matrix_wdma.
//   dat_in_vld/pd/rdy : TOUT-lane result beats from the engine datapath
//   wr_req_vld/rdy/pd : MCIF write request (command or data word)
//   wr_rsp_complete   : MCIF non-posted write completion
// Modports: master = DMA side, slave = engine/MCIF side.
interface matrix_wdma_if #(
    parameter int unsigned TOUT       = 32,
    parameter int unsigned DAT_DW     = 16,
    parameter int unsigned LOG2_BURST = 4
);
    localparam int unsigned DW   = TOUT * DAT_DW;
    localparam int unsigned PD_W = 2 + LOG2_BURST + 32 + DW;

    logic            dat_in_vld;
    logic [DW-1:0]   dat_in_pd;
    logic            dat_in_rdy;
    logic            wr_req_vld;
    logic            wr_req_rdy;
    logic [PD_W-1:0] wr_req_pd;
    logic            wr_rsp_complete;

    modport master (
        input  dat_in_vld,
        input  dat_in_pd,
        output dat_in_rdy,
        output wr_req_vld,
        input  wr_req_rdy,
        output wr_req_pd,
        input  wr_rsp_complete
    );

    modport slave (
        output dat_in_vld,
        output dat_in_pd,
        input  dat_in_rdy,
        input  wr_req_vld,
        output wr_req_rdy,
        input  wr_req_pd,
        output wr_rsp_complete
    );

endinterface

// File: rtl/matrix_wdma_addr_gen.sv
// Address/counter generator for matrix_wdma.
// Nested counters: beat (innermost) -> channel slice -> width burst -> row.
// Offsets are built from three 32-bit bias accumulators (no multipliers).
// Ports:
//   i_clr        : clear all counters (job start)
//   i_adv        : one data beat accepted
//   i_w/i_h/i_ch_div_tout/i_pixel_in/i_surface_stride/i_line_stride : job CSRs
//   o_len        : beats-1 of the current burst
//   o_offset     : byte offset of the current burst
//   o_nonposted  : current burst is the final burst of the job
//   o_last_beat  : current beat is the last of its burst
//   o_pix_zero   : current beat lies beyond the valid pixel count
module matrix_wdma_addr_gen
    import matrix_dma_pkg::*;
#(
    parameter int unsigned TOUT       = 32,
    parameter int unsigned DAT_DW     = 16,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned LOG2_BURST = 4,
    parameter int unsigned W_W        = 12,
    parameter int unsigned H_W        = 12,
    parameter int unsigned CHT_W      = 8,
    parameter int unsigned PIX_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_adv,
    input  logic [W_W-1:0]        i_w,
    input  logic [H_W-1:0]        i_h,
    input  logic [CHT_W-1:0]      i_ch_div_tout,
    input  logic [PIX_W-1:0]      i_pixel_in,
    input  logic [31:0]           i_surface_stride,
    input  logic [31:0]           i_line_stride,
    output logic [LOG2_BURST-1:0] o_len,
    output logic [31:0]           o_offset,
    output logic                  o_nonposted,
    output logic                  o_last_beat,
    output logic                  o_pix_zero
);
    localparam logic [31:0] WbStep = 32'(BURST_LEN * pb_bytes(TOUT, DAT_DW));

    logic [LOG2_BURST-1:0] r_beat_cnt;
    logic [CHT_W-1:0]      r_ch_cnt;
    logic [W_W-1:0]        r_wb_cnt;
    logic [H_W-1:0]        r_h_cnt;
    logic [31:0]           r_wb_bias;
    logic [31:0]           r_ch_bias;
    logic [31:0]           r_h_bias;
    logic [31:0]           r_row_pix;  // h_cnt * w, accumulated

    logic [W_W-1:0] w_w_m1;
    logic           w_last_wb;
    logic           w_last_ch;
    logic           w_last_h;
    logic [31:0]    w_pix;

    always_comb begin
        w_w_m1      = i_w - W_W'(1);
        w_last_wb   = (r_wb_cnt == (w_w_m1 >> LOG2_BURST));
        w_last_ch   = (r_ch_cnt == (i_ch_div_tout - CHT_W'(1)));
        w_last_h    = (r_h_cnt == (i_h - H_W'(1)));
        o_len       = w_last_wb ? w_w_m1[LOG2_BURST-1:0] : '1;
        o_last_beat = (r_beat_cnt == o_len);
        o_nonposted = w_last_wb & w_last_ch & w_last_h;
        o_offset    = r_wb_bias + r_ch_bias + r_h_bias;
        w_pix       = r_row_pix + (32'(r_wb_cnt) << LOG2_BURST) + 32'(r_beat_cnt);
        o_pix_zero  = (w_pix >= 32'(i_pixel_in));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_ch_cnt   <= '0;
            r_wb_cnt   <= '0;
            r_h_cnt    <= '0;
            r_wb_bias  <= '0;
            r_ch_bias  <= '0;
            r_h_bias   <= '0;
            r_row_pix  <= '0;
        end else if (i_clr) begin
            r_beat_cnt <= '0;
            r_ch_cnt   <= '0;
            r_wb_cnt   <= '0;
            r_h_cnt    <= '0;
            r_wb_bias  <= '0;
            r_ch_bias  <= '0;
            r_h_bias   <= '0;
            r_row_pix  <= '0;
        end else if (i_adv) begin
            if (o_last_beat) begin
                r_beat_cnt <= '0;
                if (w_last_ch) begin
                    r_ch_cnt  <= '0;
                    r_ch_bias <= '0;
                    if (w_last_wb) begin
                        r_wb_cnt  <= '0;
                        r_wb_bias <= '0;
                        r_h_cnt   <= r_h_cnt + H_W'(1);
                        r_h_bias  <= r_h_bias + i_line_stride;
                        r_row_pix <= r_row_pix + 32'(i_w);
                    end else begin
                        r_wb_cnt  <= r_wb_cnt + W_W'(1);
                        r_wb_bias <= r_wb_bias + WbStep;
                    end
                end else begin
                    r_ch_cnt  <= r_ch_cnt + CHT_W'(1);
                    r_ch_bias <= r_ch_bias + i_surface_stride;
                end
            end else begin
                r_beat_cnt <= r_beat_cnt + LOG2_BURST'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_wdma.sv
// Write-DMA for the matrix engines: streams TOUT-lane result beats into a
// channel-tiled feature map via MCIF write bursts (command word, then beats).
// Optional feature macro: MATRIX_WDMA_PERF_CNT_EN adds o_perf_busy_cyc and
// o_perf_stall_cyc.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_start             : 1-cycle job start (ignored unless idle)
//   i_w, i_h, i_ch_div_tout, i_pixel_in, i_base_addr, i_surface_stride,
//   i_line_stride       : job CSRs, held stable while busy
//   o_busy, o_done      : job active, 1-cycle completion pulse
//   wr_if               : engine stream + MCIF write port (master side)
module matrix_wdma
    import matrix_dma_pkg::*;
#(
    parameter int unsigned TOUT       = 32,
    parameter int unsigned DAT_DW     = 16,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned LOG2_BURST = 4,
    parameter int unsigned W_W        = 12,
    parameter int unsigned H_W        = 12,
    parameter int unsigned CHT_W      = 8,
    parameter int unsigned PIX_W      = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [W_W-1:0]     i_w,
    input  logic [H_W-1:0]     i_h,
    input  logic [CHT_W-1:0]   i_ch_div_tout,
    input  logic [PIX_W-1:0]   i_pixel_in,
    input  logic [31:0]        i_base_addr,
    input  logic [31:0]        i_surface_stride,
    input  logic [31:0]        i_line_stride,
    output logic               o_busy,
    output logic               o_done,
`ifdef MATRIX_WDMA_PERF_CNT_EN
    output logic [31:0]        o_perf_busy_cyc,
    output logic [31:0]        o_perf_stall_cyc,
`endif
    matrix_wdma_if.master      wr_if
);
    localparam int unsigned DW     = TOUT * DAT_DW;
    localparam int unsigned HDR_W  = 2 + LOG2_BURST + 32;
    localparam int unsigned PD_W   = HDR_W + DW;
    localparam int unsigned CMD_FW = cmd_fields_w(LOG2_BURST);
    localparam int unsigned PAD_W  = PD_W - 1 - CMD_FW;

    dma_state_e r_state;
    logic       r_busy;
    logic       r_done;

    logic                  w_dims_ok;
    logic                  w_start_job;
    logic                  w_req_vld;
    logic                  w_beat_acc;
    logic [LOG2_BURST-1:0] w_len;
    logic [31:0]           w_offset;
    logic                  w_nonposted;
    logic                  w_last_beat;
    logic                  w_pix_zero;
    logic [CmdPackW-1:0]   w_cmd_fields;
    logic                  w_unused_fields;
    logic [PD_W-1:0]       w_cmd;
    logic [DW-1:0]         w_beat;
    logic [PD_W-1:0]       w_dat;

    always_comb begin
        w_dims_ok   = (i_w != '0) && (i_h != '0) && (i_ch_div_tout != '0);
        w_start_job = (r_state == StIdle) && i_start && w_dims_ok;
        w_req_vld   = (r_state == StCmd) || ((r_state == StDat) && wr_if.dat_in_vld);
        w_beat_acc  = (r_state == StDat) && wr_if.dat_in_vld && wr_if.wr_req_rdy;

        w_cmd_fields    = pack_cmd(i_base_addr, w_nonposted, 16'(w_len), w_offset, LOG2_BURST);
        w_unused_fields = ^w_cmd_fields[CmdPackW-1:CMD_FW];
        w_cmd           = {1'b1, {PAD_W{1'b0}}, w_cmd_fields[CMD_FW-1:0]};
        // Beats past the valid pixel count are written as zero padding.
        w_beat          = w_pix_zero ? '0 : wr_if.dat_in_pd;
        w_dat           = {{HDR_W{1'b0}}, w_beat};
    end

    assign wr_if.wr_req_vld = w_req_vld;
    assign wr_if.wr_req_pd  = (r_state == StCmd) ? w_cmd : w_dat;
    assign wr_if.dat_in_rdy = (r_state == StDat) && wr_if.wr_req_rdy;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

    matrix_wdma_addr_gen #(
        .TOUT       (TOUT),
        .DAT_DW     (DAT_DW),
        .BURST_LEN  (BURST_LEN),
        .LOG2_BURST (LOG2_BURST),
        .W_W        (W_W),
        .H_W        (H_W),
        .CHT_W      (CHT_W),
        .PIX_W      (PIX_W)
    ) u_addr_gen (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_clr            (w_start_job),
        .i_adv            (w_beat_acc),
        .i_w              (i_w),
        .i_h              (i_h),
        .i_ch_div_tout    (i_ch_div_tout),
        .i_pixel_in       (i_pixel_in),
        .i_surface_stride (i_surface_stride),
        .i_line_stride    (i_line_stride),
        .o_len            (w_len),
        .o_offset         (w_offset),
        .o_nonposted      (w_nonposted),
        .o_last_beat      (w_last_beat),
        .o_pix_zero       (w_pix_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_dims_ok) begin
                            r_state <= StCmd;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                StCmd: begin
                    if (wr_if.wr_req_rdy) begin
                        r_state <= StDat;
                    end
                end
                StDat: begin
                    if (w_beat_acc && w_last_beat) begin
                        r_state <= w_nonposted ? StWaitRsp : StCmd;
                    end
                end
                StWaitRsp: begin
                    if (wr_if.wr_rsp_complete) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef MATRIX_WDMA_PERF_CNT_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == StIdle) && i_start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (w_req_vld && !wr_if.wr_req_rdy) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_busy_cyc  = r_perf_busy;
    assign o_perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_matrix_wdma.sv
// Self-checking bench for matrix_wdma: builds the expected MCIF word stream of
// each job from the addressing rules, drives random engine beats and ready
// back-pressure, and compares every accepted request word.
module tb_matrix_wdma;
    localparam int unsigned TOUT       = 32;
    localparam int unsigned DAT_DW     = 16;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned LOG2_BURST = 4;
    localparam int unsigned W_W        = 12;
    localparam int unsigned H_W        = 12;
    localparam int unsigned CHT_W      = 8;
    localparam int unsigned PIX_W      = 24;
    localparam int unsigned DW         = TOUT * DAT_DW;
    localparam int unsigned PD_W       = 2 + LOG2_BURST + 32 + DW;
    localparam int unsigned PB         = DW / 8;
    localparam int unsigned MAXB       = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start;
    logic [W_W-1:0]   i_w;
    logic [H_W-1:0]   i_h;
    logic [CHT_W-1:0] i_ch_div_tout;
    logic [PIX_W-1:0] i_pixel_in;
    logic [31:0]      i_base_addr;
    logic [31:0]      i_surface_stride;
    logic [31:0]      i_line_stride;
    logic             o_busy;
    logic             o_done;
`ifdef MATRIX_WDMA_PERF_CNT_EN
    logic [31:0]      perf_busy_cyc;
    logic [31:0]      perf_stall_cyc;
`endif

    matrix_wdma_if #(.TOUT(TOUT), .DAT_DW(DAT_DW), .LOG2_BURST(LOG2_BURST)) bus ();

    matrix_wdma #(
        .TOUT(TOUT), .DAT_DW(DAT_DW), .BURST_LEN(BURST_LEN), .LOG2_BURST(LOG2_BURST),
        .W_W(W_W), .H_W(H_W), .CHT_W(CHT_W), .PIX_W(PIX_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_w              (i_w),
        .i_h              (i_h),
        .i_ch_div_tout    (i_ch_div_tout),
        .i_pixel_in       (i_pixel_in),
        .i_base_addr      (i_base_addr),
        .i_surface_stride (i_surface_stride),
        .i_line_stride    (i_line_stride),
        .o_busy           (o_busy),
        .o_done           (o_done),
`ifdef MATRIX_WDMA_PERF_CNT_EN
        .o_perf_busy_cyc  (perf_busy_cyc),
        .o_perf_stall_cyc (perf_stall_cyc),
`endif
        .wr_if            (bus)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int vld_cnt = 0;
    int src_idx = 0;
    int src_n = 0;
    bit rand_mode = 1'b0;
    logic [DW-1:0]   src_mem [MAXB];
    logic [PD_W-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_w(input string nm, input logic [PD_W-1:0] act, input logic [PD_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [PD_W-1:0] cmd_word(input logic [31:0] base, input bit np,
                                                 input int unsigned len, input logic [31:0] off);
        logic [PD_W-1:0] r;
        r = '0;
        r[PD_W-1]               = 1'b1;
        r[31:0]                 = off;
        r[32 +: LOG2_BURST]     = LOG2_BURST'(len);
        r[32 + LOG2_BURST]      = np;
        r[33 + LOG2_BURST +: 32] = base;
        return r;
    endfunction

    // Expected stream: for each row, width burst, channel slice -> cmd then beats.
    task automatic setup_job(input int w, input int h, input int ch, input int pix,
                             input logic [31:0] base, input logic [31:0] ss,
                             input logic [31:0] ls);
        int k;
        int nwb;
        k = 0;
        i_w = W_W'(w); i_h = H_W'(h); i_ch_div_tout = CHT_W'(ch); i_pixel_in = PIX_W'(pix);
        i_base_addr = base; i_surface_stride = ss; i_line_stride = ls;
        for (int i = 0; i < h * ch * w; i++)
            for (int j = 0; j < DW / 32; j++) src_mem[i][j*32 +: 32] = $urandom();
        exp_q.delete();
        nwb = (w - 1) / BURST_LEN + 1;
        for (int hh = 0; hh < h; hh++)
            for (int wb = 0; wb < nwb; wb++)
                for (int c = 0; c < ch; c++) begin
                    int nb;
                    bit np;
                    logic [31:0] off;
                    nb = (wb == nwb - 1) ? ((w - 1) % BURST_LEN) + 1 : BURST_LEN;
                    np = (hh == h - 1) && (wb == nwb - 1) && (c == ch - 1);
                    off = 32'(wb * BURST_LEN * PB) + 32'(c) * ss + 32'(hh) * ls;
                    exp_q.push_back(cmd_word(base, np, nb - 1, off));
                    for (int b = 0; b < nb; b++) begin
                        int p;
                        p = hh * w + wb * BURST_LEN + b;
                        exp_q.push_back((p >= pix) ? '0 : PD_W'(src_mem[k]));
                        k++;
                    end
                end
        src_n = 0;
    endtask

    task automatic run_job(input bit events);
        int total;
        int d0;
        bit rsp_sent;
        total = exp_q.size();
        rsp_sent = 1'b0;
        src_idx = 0;
        src_n = int'(i_h) * int'(i_ch_div_tout) * int'(i_w);
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        d0 = done_cnt;
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) begin
            i_start = events && (c == 6);
            if (events && !rsp_sent && exp_q.size() < total / 2) begin
                bus.wr_rsp_complete = 1'b1;
                rsp_sent = 1'b1;
            end else begin
                bus.wr_rsp_complete = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        bus.wr_rsp_complete = 1'b0;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL job_timeout: got %0d words outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        chk("no_early_done", 64'(done_cnt), 64'(d0));
        chk("busy_in_wait", 64'(o_busy), 64'd1);
        bus.wr_rsp_complete = 1'b1;
        @(posedge clk); #1 bus.wr_rsp_complete = 1'b0;
        chk("done_pulse", 64'(o_done), 64'd1);
        @(posedge clk); #1;
        chk("done_clear", 64'(o_done), 64'd0);
        chk("busy_clear", 64'(o_busy), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(d0 + 1));
        src_n = 0;
    endtask

    // Engine beat source and MCIF ready driver.
    initial begin
        bit acc;
        bus.dat_in_vld = 1'b0;
        bus.dat_in_pd  = '0;
        bus.wr_req_rdy = 1'b0;
        forever begin
            @(negedge clk);
            acc = rst_n && bus.dat_in_vld && bus.dat_in_rdy;
            @(posedge clk);
            #1;
            if (acc) begin
                src_idx++;
                bus.dat_in_vld = 1'b0;
            end
            if (src_idx < src_n) begin
                if (!bus.dat_in_vld) bus.dat_in_vld = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                bus.dat_in_pd = src_mem[src_idx];
            end else begin
                bus.dat_in_vld = 1'b0;
            end
            bus.wr_req_rdy = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Compare process: every accepted request word against the model queue.
    initial begin
        bit held;
        logic [PD_W-1:0] held_pd;
        logic [PD_W-1:0] e;
        held = 1'b0;
        held_pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                chk("hold_vld", 64'(bus.wr_req_vld), 64'd1);
                chk_w("hold_pd", bus.wr_req_pd, held_pd);
            end
            if (bus.wr_req_vld) vld_cnt++;
            if (o_done) done_cnt++;
            if (bus.wr_req_vld && bus.wr_req_rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_req: got %h expected no request", bus.wr_req_pd);
                end else begin
                    e = exp_q.pop_front();
                    chk_w("req_word", bus.wr_req_pd, e);
                end
            end
            held = bus.wr_req_vld && !bus.wr_req_rdy;
            held_pd = bus.wr_req_pd;
        end
    end

    initial begin
        int v0;
        int ncmd;
        int npc;
        logic [31:0] offs [8];
        int lens [8];
        i_start = 1'b0;
        bus.wr_rsp_complete = 1'b0;
        setup_job(1, 1, 1, 1, 32'h0, 32'h0, 32'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_req_vld", 64'(bus.wr_req_vld), 64'd0);
        chk("rst_dat_rdy", 64'(bus.dat_in_rdy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single burst, always ready.
        rand_mode = 1'b0;
        setup_job(16, 1, 1, 16, 32'h1000, 32'h0, 32'h0);
        chk("A_words", 64'(exp_q.size()), 64'd17);
        chk_w("A_cmd", exp_q[0], {1'b1, 480'd0, 32'h1000, 1'b1, 4'd15, 32'd0});
        run_job(1'b0);

        // Multi-burst, channel slices, back-pressure, ignored start/rsp mid-job.
        rand_mode = 1'b1;
        setup_job(20, 2, 2, 1000, 32'h2000, 32'h10000, 32'h800);
        ncmd = 0;
        npc = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i][PD_W-1]) begin
                if (ncmd < 8) begin
                    offs[ncmd] = exp_q[i][31:0];
                    lens[ncmd] = int'(exp_q[i][35:32]);
                end
                if (exp_q[i][36]) npc++;
                ncmd++;
            end
        end
        chk("B_ncmd", 64'(ncmd), 64'd8);
        chk("B_off1", 64'(offs[1]), 64'h10000);
        chk("B_off2", 64'(offs[2]), 64'h400);
        chk("B_off3", 64'(offs[3]), 64'h10400);
        chk("B_off4", 64'(offs[4]), 64'h800);
        chk("B_len0", 64'(lens[0]), 64'd15);
        chk("B_len2", 64'(lens[2]), 64'd3);
        chk("B_np", 64'(npc), 64'd1);
        run_job(1'b1);

        // Pixel zeroing: pix 30..39 zero.
        setup_job(20, 2, 1, 30, 32'h4000, 32'h0, 32'h1000);
        chk_w("C_pix29", exp_q[32], PD_W'(src_mem[29]));
        chk_w("C_pix30", exp_q[33], '0);
        run_job(1'b0);

        // Zero dimension: done next cycle, no requests.
        for (int z = 0; z < 3; z++) begin
            i_w = (z == 0) ? '0 : W_W'(4);
            i_h = (z == 1) ? '0 : H_W'(1);
            i_ch_div_tout = (z == 2) ? '0 : CHT_W'(1);
            v0 = vld_cnt;
            @(posedge clk); #1 i_start = 1'b1;
            @(posedge clk); #1 i_start = 1'b0;
            chk("zero_done", 64'(o_done), 64'd1);
            chk("zero_busy", 64'(o_busy), 64'd0);
            @(posedge clk); #1;
            chk("zero_done_clr", 64'(o_done), 64'd0);
            repeat (3) @(posedge clk);
            chk("zero_no_req", 64'(vld_cnt), 64'(v0));
        end

        // Random jobs.
        for (int j = 0; j < 6; j++) begin
            int w;
            int h;
            w = $urandom_range(1, 40);
            h = $urandom_range(1, 3);
            setup_job(w, h, $urandom_range(1, 3), $urandom_range(0, w * h + 3),
                      $urandom(), $urandom(), $urandom());
            run_job(j[0]);
        end

        // Reset mid-burst.
        setup_job(40, 2, 2, 200, 32'h8000, 32'h20000, 32'h4000);
        src_idx = 0;
        src_n = 160;
        v0 = exp_q.size();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int c = 0; c < 2000 && exp_q.size() > v0 - 10; c++) @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_done", 64'(o_done), 64'd0);
        chk("mid_rst_req_vld", 64'(bus.wr_req_vld), 64'd0);
        chk("mid_rst_dat_rdy", 64'(bus.dat_in_rdy), 64'd0);
        src_n = 0;
        src_idx = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        setup_job(23, 2, 3, 40, 32'hA000, 32'h3000, 32'h900);
        run_job(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
